// File: rtl/gsim_residual.sv
// Residual checker for the GSIM solver: captures b and x frames, recomputes
// r = M*x - b for the fixed 16x16 banded matrix, streams r and flags rows over TOL.
module gsim_residual #(
    parameter int unsigned TOL   = 256,
    parameter int unsigned ACC_W = 40
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_en,
    input  logic [15:0]      b_in,
    input  logic             out_valid,
    input  logic [31:0]      x_out,
    output logic             res_valid,
    output logic [ACC_W-1:0] res_out,
    output logic [4:0]       err_cnt,
    output logic             pass,
    output logic             done,
    output logic             busy
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StCalc = 2'd1;
    localparam logic [1:0] StEmit = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    logic [15:0] b_mem [16];
    logic [31:0] x_mem [16];

    logic [1:0]              state_q;
    logic [4:0]              bc_q, xc_q;
    logic [3:0]              row_q;
    logic [2:0]              k_q;
    logic signed [ACC_W-1:0] acc_q;

    logic                    idle, b_we, x_we;
    logic [4:0]              bc_d, xc_d;
    logic [5:0]              col;
    logic                    col_ok;
    logic [31:0]             x_sel;
    logic [15:0]             b_sel;
    logic signed [ACC_W-1:0] x_ext, term, acc_sum, b_ext, res_calc;
    logic [ACC_W-1:0]        res_abs;
    logic                    over_tol;

    // Capture enables; counters stop at 16 so surplus words are dropped
    always_comb begin
        idle = (state_q == StIdle);
        b_we = idle && in_en && !bc_q[4];
        x_we = idle && out_valid && !xc_q[4];
        bc_d = bc_q + {4'd0, b_we};
        xc_d = xc_q + {4'd0, x_we};
    end

    // Frame buffers, written in arrival order (not reset)
    always_ff @(posedge clk) begin
        if (b_we) b_mem[bc_q[3:0]] <= b_in;
        if (x_we) x_mem[xc_q[3:0]] <= x_out;
    end

    // One matrix tap per cycle: column j = row + k - 3, coefficient by |k - 3|
    always_comb begin
        // Negative columns wrap to >= 61, so one unsigned compare covers both edges
        col     = {2'b00, row_q} + {3'b000, k_q} - 6'd3;
        col_ok  = (col < 6'd16);
        x_sel   = x_mem[col[3:0]];
        b_sel   = b_mem[row_q];
        x_ext   = {{(ACC_W-32){x_sel[31]}}, x_sel};
        term    = '0;
        if (col_ok) begin
            case (k_q)
                3'd3:       term = (x_ext <<< 4) + (x_ext <<< 2);
                3'd2, 3'd4: term = -((x_ext <<< 3) + (x_ext <<< 2) + x_ext);
                3'd1, 3'd5: term = (x_ext <<< 2) + (x_ext <<< 1);
                default:    term = -x_ext;
            endcase
        end
        acc_sum  = ((k_q == 3'd0) ? '0 : acc_q) + term;
        b_ext    = {{(ACC_W-32){b_sel[15]}}, b_sel, 16'h0000};
        res_calc = acc_sum - b_ext;
        res_abs  = res_calc[ACC_W-1] ? ACC_W'(-res_calc) : ACC_W'(res_calc);
        over_tol = (res_abs > ACC_W'(TOL));
    end

    // Control FSM and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            bc_q      <= '0;
            xc_q      <= '0;
            row_q     <= '0;
            k_q       <= '0;
            acc_q     <= '0;
            res_valid <= 1'b0;
            res_out   <= '0;
            err_cnt   <= '0;
            pass      <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    bc_q <= bc_d;
                    xc_q <= xc_d;
                    // First captured word of a frame clears the previous verdict
                    if ((b_we || x_we) && bc_q == 5'd0 && xc_q == 5'd0) begin
                        err_cnt <= '0;
                        pass    <= 1'b0;
                    end
                    if (bc_d == 5'd16 && xc_d == 5'd16) begin
                        state_q <= StCalc;
                        busy    <= 1'b1;
                        row_q   <= '0;
                        k_q     <= '0;
                    end
                end
                StCalc: begin
                    acc_q <= acc_sum;
                    k_q   <= k_q + 3'd1;
                    if (k_q == 3'd6) begin
                        state_q   <= StEmit;
                        res_valid <= 1'b1;
                        res_out   <= res_calc;
                        if (over_tol) err_cnt <= err_cnt + 5'd1;
                    end
                end
                StEmit: begin
                    res_valid <= 1'b0;
                    k_q       <= '0;
                    if (row_q == 4'd15) begin
                        state_q <= StDone;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= (err_cnt == 5'd0);
                    end else begin
                        row_q   <= row_q + 4'd1;
                        state_q <= StCalc;
                    end
                end
                default: begin
                    done    <= 1'b0;
                    bc_q    <= '0;
                    xc_q    <= '0;
                    row_q   <= '0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gsim_residual.sv
// Randomized self-checking bench for gsim_residual against a plain-arithmetic
// residual model; a second instance with TOL=16 exercises the tolerance compare.
module tb_gsim_residual;

    localparam int ACC_W = 40;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             in_en = 1'b0;
    logic [15:0]      b_in = '0;
    logic             out_valid = 1'b0;
    logic [31:0]      x_out = '0;

    logic             res_valid, pass, done, busy;
    logic [ACC_W-1:0] res_out;
    logic [4:0]       err_cnt;
    logic             res_valid16, pass16, done16, busy16;
    logic [ACC_W-1:0] res_out16;
    logic [4:0]       err_cnt16;

    gsim_residual #(.TOL(256), .ACC_W(ACC_W)) dut (
        .clk(clk), .reset(reset), .in_en(in_en), .b_in(b_in),
        .out_valid(out_valid), .x_out(x_out),
        .res_valid(res_valid), .res_out(res_out), .err_cnt(err_cnt),
        .pass(pass), .done(done), .busy(busy)
    );

    gsim_residual #(.TOL(16), .ACC_W(ACC_W)) dut16 (
        .clk(clk), .reset(reset), .in_en(in_en), .b_in(b_in),
        .out_valid(out_valid), .x_out(x_out),
        .res_valid(res_valid16), .res_out(res_out16), .err_cnt(err_cnt16),
        .pass(pass16), .done(done16), .busy(busy16)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] fb [16];
    logic [31:0] fx [16];
    longint      exp_r [16];
    int          exp_err, exp_err16;

    task automatic check_eq(input string tag, input logic signed [63:0] got,
                            input logic signed [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // r[i] = sum_j M(|i-j|) * x[j] - b[i] * 2^16, all in 64-bit integers
    function automatic void build_model();
        exp_err   = 0;
        exp_err16 = 0;
        for (int i = 0; i < 16; i++) begin
            longint acc = 0;
            longint a;
            for (int j = 0; j < 16; j++) begin
                int d = (i > j) ? i - j : j - i;
                longint m = (d == 0) ? 20 : (d == 1) ? -13 : (d == 2) ? 6 : (d == 3) ? -1 : 0;
                acc += m * longint'($signed(fx[j]));
            end
            exp_r[i] = acc - longint'($signed(fb[i])) * 65536;
            a = (exp_r[i] < 0) ? -exp_r[i] : exp_r[i];
            if (a > 256) exp_err++;
            if (a > 16)  exp_err16++;
        end
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_res_valid"}, res_valid, 0);
        check_eq({tag, "_res_out"}, longint'($signed(res_out)), 0);
        check_eq({tag, "_err_cnt"}, err_cnt, 0);
        check_eq({tag, "_pass"}, pass, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_busy"}, busy, 0);
    endtask

    // mode 0: both streams together; 1: all x first, 8 overlap cycles of surplus x
    // while b starts; 2: random interleave with surplus words. abort_at >= 0 drops
    // reset that many cycles into CALC.
    task automatic run_frame(input int mode, input int abort_at);
        int   nb, nx, t, s, rows, seen_done, stray;
        logic eb, ex;
        build_model();
        nb = 0; nx = 0; t = 0;
        while ((nb < 16 || nx < 16) && t < 400) begin
            @(negedge clk);
            if (t == 1) begin
                check_eq("clear_pass", pass, 0);
                check_eq("clear_err", err_cnt, 0);
            end
            case (mode)
                0: begin eb = 1'b1; ex = 1'b1; end
                1: begin ex = (t < 24); eb = (t >= 16); end
                default: begin
                    eb = 1'($urandom);
                    ex = 1'($urandom);
                    if (t == 0) eb = 1'b1;
                end
            endcase
            in_en     = eb;
            b_in      = (nb < 16) ? fb[nb] : 16'($urandom);
            out_valid = ex;
            x_out     = (nx < 16) ? fx[nx] : $urandom;
            if (eb && nb < 16) nb++;
            if (ex && nx < 16) nx++;
            t++;
        end
        @(negedge clk);
        in_en     = 1'b0;
        out_valid = 1'b0;
        s = 0;
        rows = 0;
        seen_done = 0;
        check_eq("busy_start", busy, 1);
        while (s < 140 && seen_done == 0) begin
            if (s == abort_at) begin
                reset = 1'b0;
                #1;
                check_reset_outputs("abort");
                @(negedge clk);
                reset = 1'b1;
                stray = 0;
                repeat (200) begin
                    @(negedge clk);
                    if (res_valid || done || res_valid16 || done16) stray++;
                end
                check_eq("abort_stray", stray, 0);
                return;
            end
            if (res_valid) begin
                check_eq($sformatf("row%0d_time", rows), s, 8 * rows + 7);
                if (rows < 16)
                    check_eq($sformatf("row%0d_res", rows), longint'($signed(res_out)),
                             exp_r[rows]);
                rows++;
            end
            if (s == 127) check_eq("busy_end", busy, 1);
            if (done) begin
                seen_done = 1;
                check_eq("done_time", s, 128);
                check_eq("rows_seen", rows, 16);
                check_eq("err_cnt", err_cnt, exp_err);
                check_eq("pass", pass, (exp_err == 0) ? 1 : 0);
                check_eq("busy_done", busy, 0);
                check_eq("done16", done16, 1);
                check_eq("err_cnt16", err_cnt16, exp_err16);
                check_eq("pass16", pass16, (exp_err16 == 0) ? 1 : 0);
            end
            @(negedge clk);
            s++;
        end
        if (seen_done == 0) check_eq("done_seen", 0, 1);
    endtask

    initial begin
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        reset = 1'b1;

        // all zero
        for (int i = 0; i < 16; i++) begin fb[i] = '0; fx[i] = '0; end
        run_frame(0, -1);

        // x = 1.0 everywhere, b matches row sums -> all residuals zero
        for (int i = 0; i < 16; i++) begin
            fx[i] = 32'h0001_0000;
            fb[i] = (i == 0 || i == 15) ? 16'd12 : (i == 1 || i == 14) ? 16'hFFFF :
                    (i == 2 || i == 13) ? 16'd5 : 16'd4;
        end
        run_frame(2, -1);

        // same x, b = 0 -> every row fails
        for (int i = 0; i < 16; i++) fb[i] = '0;
        run_frame(0, -1);

        // single LSB in x[5]: only the TOL=16 instance sees one violation
        for (int i = 0; i < 16; i++) fx[i] = '0;
        fx[5] = 32'h0000_0001;
        run_frame(2, -1);

        // b[0] = -1, x streamed entirely before b with overlapping surplus strobes
        fx[5] = '0;
        fb[0] = 16'hFFFF;
        run_frame(1, -1);

        // reset during row 6, then a fresh frame
        for (int i = 0; i < 16; i++) begin fb[i] = 16'($urandom); fx[i] = $urandom; end
        run_frame(0, 51);

        for (int f = 0; f < 5; f++) begin
            for (int i = 0; i < 16; i++) begin
                if (f < 3) begin
                    fb[i] = 16'($urandom);
                    fx[i] = $urandom;
                end else begin
                    fb[i] = '0;
                    fx[i] = 32'($urandom_range(0, 40)) - 32'd20;
                end
            end
            run_frame(f % 3, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gsim_residual.md
# gsim_residual

Downstream checker for the GSIM solver. It captures the 16 signed integer right-hand-side values `b` on the solver's input bus and the 16 Q16.16 solution words on its output bus. It then recomputes each row residual r[i] = (M·x)[i] − b[i] for the fixed 16×16 banded matrix and reports every residual, a violation count and a pass flag. It replaces the bench's floating-point error check with a synthesizable in-system self-check.

## Interface
- `TOL`, default 256: pass threshold on |r[i]| in Q16.16 LSBs (256 = 2^-8).
- `ACC_W`, default 40: accumulator and residual width, signed.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-low reset.
- `in_en`  in  1  b-word strobe, tapped from the GSIM input bus.
- `b_in`  in  16  signed integer b word, valid when `in_en`=1.
- `out_valid`  in  1  x-word strobe, tapped from the GSIM output bus.
- `x_out`  in  32  signed Q16.16 x word, valid when `out_valid`=1.
- `res_valid`  out  1  one-cycle strobe, one per row, rows 0..15 in order.
- `res_out`  out  ACC_W  signed Q(ACC_W−16).16 residual r[i].
- `err_cnt`  out  5  number of rows with |r|>TOL; valid from `done`.
- `pass`  out  1  1 iff `err_cnt`==0; valid from `done`, held until next frame.
- `done`  out  1  one-cycle pulse after the row-15 residual.
- `busy`  out  1  high in CALC and EMIT.

## Operation
- Storage: b buffer 16×16 and x buffer 16×32, written in arrival order by independent 5-bit counters `bc` and `xc` that saturate at 16.
- Matrix: M[i][j] depends on d=|i−j|. Values: d=0→20, d=1→−13, d=2→6, d=3→−1, d>3→0.
- Coefficient multiplies use shift-add only (20=16+4, 13=8+4+1, 6=4+2). No multiplier.
- FSM states: IDLE → CALC → EMIT → (CALC | DONE) → IDLE.
- IDLE: capture on `in_en` and `out_valid` independently. Both may assert in the same cycle, and the two streams may arrive in either order or interleaved. Leave IDLE the cycle after `bc`==16 and `xc`==16 are both true.
- CALC: row i, tap k=0..6 (one per cycle), column j=i+k−3.
  - The accumulator clears at k=0.
  - A tap with j<0 or j>15 adds 0, so every row takes exactly 7 cycles.
  - Every x word is sign-extended to ACC_W before shift-add.
- EMIT (1 cycle): `res_out` = acc − sign_ext(b[i])<<16, and `res_valid`=1.
  - If |res_out|>TOL, `err_cnt` increments (unsigned, cannot overflow at 16).
  - Go to CALC for row i+1, or to DONE after row 15.
- DONE (1 cycle):
  - `done`=1 and `pass`=(err_cnt==0).
  - Clear `bc`, `xc` and the row index.
  - Go to IDLE.
- `in_en` and `out_valid` are ignored outside IDLE. Words beyond the 16th in IDLE are ignored, because the counters saturate.
- The next frame starts capturing in IDLE. `err_cnt` and `pass` are cleared on the first captured word of the new frame.
- Arithmetic is two's complement throughout. The maximum |M·x| is 60·2^31, which fits in 38 bits, so ACC_W=40 gives no overflow.

## Timing
- Reset values: `res_valid`=0, `res_out`=0, `err_cnt`=0, `pass`=0, `done`=0, `busy`=0, FSM=IDLE, all counters=0. Buffers are not reset.
- Let C be the first CALC cycle, which is the cycle after the later of the 16th b and 16th x captures.
- Row i `res_valid` is at cycle C+8i+7. `done` is at C+128. `busy` is high for cycles C..C+127.
- Outputs are registered. `res_out` holds its value until the next EMIT.
- Reset asserted at any point, including mid-CALC, restores all reset values immediately and aborts the frame. No partial `res_valid` or `done` follows. A complete new frame after release must work normally.

## Test plan
- b all 0, x all 0 → 16 `res_valid` pulses with `res_out`=0, then `done`, `err_cnt`=0, `pass`=1.
- x all 0x00010000, b = {12,−1,5,4,4,4,4,4,4,4,4,4,4,5,−1,12} → all residuals 0, `pass`=1.
- Same x, b all 0 → row0 `res_out`=0x0C0000, row1=−0x010000, row3=0x040000, `err_cnt`=16, `pass`=0.
- TOL=16, b all 0, x[5]=0x00000001, others 0 → rows 2..8 give −1,6,−13,20,−13,6,−1 LSB, other rows 0, `err_cnt`=1, `pass`=0.
- b[0]=0xFFFF (−1), x all 0, with all 16 x words sent before any b and `in_en`/`out_valid` overlapping on 8 cycles → row0 `res_out`=0x010000. Row-0 `res_valid` must occur exactly 7 cycles after the first CALC cycle.
- Drop `reset` during row 6 of CALC → outputs return to 0 and no further `res_valid` or `done` occur. Then run frame 2 → correct results, and `done` arrives at C+128.
